// File: rtl/rv_pkg.sv
// rv_pkg: RV32I decode constants, ALU op/result-select encodings and mapping helpers
package rv_pkg;
    localparam int AluOpW = 4;
    localparam int AluSelW = 2;
    localparam logic [4:0] REG_NOP = 5'd0;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP = 7'b0110011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_SLL = 3'd1;
    localparam logic [2:0] F3_SLT = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR = 3'd4;
    localparam logic [2:0] F3_SR = 3'd5;
    localparam logic [2:0] F3_OR = 3'd6;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [AluOpW-1:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [AluSelW-1:0] {RES_NOP, RES_ARITH, RES_LOGIC, RES_SHIFT} alu_sel_e;

    function automatic alu_op_e f3_op(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD: return alt ? ALU_SUB : ALU_ADD;
            F3_SLL: return ALU_SLL;
            F3_SLT: return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR: return ALU_XOR;
            F3_SR: return alt ? ALU_SRA : ALU_SRL;
            F3_OR: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_sel_e sel_of(input alu_op_e op);
        return op inside {ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU} ? RES_ARITH :
               op inside {ALU_XOR, ALU_OR, ALU_AND} ? RES_LOGIC :
               op inside {ALU_SLL, ALU_SRL, ALU_SRA} ? RES_SHIFT : RES_NOP;
    endfunction
endpackage

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: IF/ID input, regfile read, forwarding and ID/EX output bundle
interface id_stage_pipe_if #(parameter int XLEN = 32, parameter int NFWD = 2, parameter int RA_W = 5);
    import rv_pkg::*;
    logic flush;
    logic in_valid;
    logic in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0] in_inst;
    logic [RA_W-1:0] rs1_addr_o;
    logic [RA_W-1:0] rs2_addr_o;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [NFWD-1:0] fwd_wen;
    logic [NFWD*RA_W-1:0] fwd_waddr;
    logic [NFWD*XLEN-1:0] fwd_wdata;
    logic [NFWD-1:0] fwd_pending;
    logic out_valid;
    logic out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    alu_op_e out_aluop;
    alu_sel_e out_alusel;
    logic [RA_W-1:0] out_rd;
    logic out_wreg;
    logic out_illegal;

    modport master (
        output flush, in_valid, in_pc, in_inst, rs1_data_i, rs2_data_i,
        output fwd_wen, fwd_waddr, fwd_wdata, fwd_pending, out_ready,
        input in_ready, rs1_addr_o, rs2_addr_o, out_valid, out_pc, out_imm,
        input out_op1, out_op2, out_aluop, out_alusel, out_rd, out_wreg, out_illegal
    );

    modport slave (
        input flush, in_valid, in_pc, in_inst, rs1_data_i, rs2_data_i,
        input fwd_wen, fwd_waddr, fwd_wdata, fwd_pending, out_ready,
        output in_ready, rs1_addr_o, rs2_addr_o, out_valid, out_pc, out_imm,
        output out_op1, out_op2, out_aluop, out_alusel, out_rd, out_wreg, out_illegal
    );
endinterface

// File: rtl/rv_imm_gen.sv
// rv_imm_gen: I-type / U-type immediate extraction with sign extension to XLEN
module rv_imm_gen #(parameter int XLEN = 32) (
    input  logic [31:0]     inst,
    input  logic            u_type,
    output logic [XLEN-1:0] imm
);
    assign imm = u_type ? XLEN'($signed({inst[31:12], 12'h000})) : XLEN'($signed(inst[31:20]));
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I decode with N-source forwarding, load-use stall and registered ID/EX output
module id_stage_pipe import rv_pkg::*; #(
    parameter int XLEN = 32,
    parameter int NFWD = 2,
    parameter int RA_W = 5
) (
    input logic clk,
    input logic rst,
    id_stage_pipe_if.slave bus
);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic is_imm, is_op, is_lui, is_auipc, imm_ok, op_ok, legal, alt, use1, use2;
    logic hazard, adv, in_ready;
    logic [XLEN-1:0] imm, src1, src2, f1, f2, op1, op2;
    logic [NFWD-1:0] hit1, hit2, first1, first2;
    logic [NFWD-1:0][XLEN-1:0] m1, m2;
    alu_op_e aluop;

    assign opc = bus.in_inst[6:0];
    assign f3 = bus.in_inst[14:12];
    assign f7 = bus.in_inst[31:25];
    assign rs1 = bus.in_inst[19:15];
    assign rs2 = bus.in_inst[24:20];
    assign rd = bus.in_inst[11:7];
    assign bus.rs1_addr_o = rs1;
    assign bus.rs2_addr_o = rs2;

    assign is_imm = opc == OPC_OP_IMM;
    assign is_op = opc == OPC_OP;
    assign is_lui = opc == OPC_LUI;
    assign is_auipc = opc == OPC_AUIPC;
    assign imm_ok = is_imm & (f3 == F3_SLL ? f7 == F7_BASE :
                              f3 == F3_SR ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1);
    assign op_ok = is_op & (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
    assign legal = imm_ok | op_ok | is_lui | is_auipc;
    // funct7 bit 5 only selects SUB/SRA for OP and for the OP-IMM right shift; elsewhere it is immediate data
    assign alt = f7 == F7_ALT && (is_op || f3 == F3_SR);
    assign aluop = !legal ? ALU_NOP : (is_lui | is_auipc) ? ALU_ADD : f3_op(f3, alt);
    assign use1 = imm_ok | op_ok;
    assign use2 = op_ok;

    rv_imm_gen #(.XLEN(XLEN)) u_imm (.inst(bus.in_inst), .u_type(is_lui | is_auipc), .imm(imm));

    for (genvar k = 0; k < NFWD; k++) begin : g_fwd
        assign hit1[k] = bus.fwd_wen[k] && bus.fwd_waddr[k*RA_W +: RA_W] == rs1;
        assign hit2[k] = bus.fwd_wen[k] && bus.fwd_waddr[k*RA_W +: RA_W] == rs2;
        assign m1[k] = first1[k] ? bus.fwd_wdata[k*XLEN +: XLEN] : '0;
        assign m2[k] = first2[k] ? bus.fwd_wdata[k*XLEN +: XLEN] : '0;
    end
    // lowest-index hit wins: isolate the least significant set bit
    assign first1 = hit1 & (-hit1);
    assign first2 = hit2 & (-hit2);

    // collapse the one-hot masked forwarding values into a single operand per source
    always_comb begin
        f1 = '0;
        f2 = '0;
        for (int k = 0; k < NFWD; k++) begin
            f1 = f1 | m1[k];
            f2 = f2 | m2[k];
        end
    end

    assign src1 = rs1 == '0 ? '0 : |hit1 ? f1 : bus.rs1_data_i;
    assign src2 = rs2 == '0 ? '0 : |hit2 ? f2 : bus.rs2_data_i;
    assign op1 = is_auipc ? bus.in_pc : use1 ? src1 : '0;
    assign op2 = op_ok ? src2 : legal ? imm : '0;

    assign hazard = (use1 && rs1 != '0 && |(first1 & bus.fwd_pending)) ||
                    (use2 && rs2 != '0 && |(first2 & bus.fwd_pending));
    assign adv = !bus.out_valid || bus.out_ready;
    assign in_ready = adv && !hazard && !bus.flush;
    assign bus.in_ready = in_ready;

    // ID/EX register: reset beats flush, flush beats advance; payload held unless an instruction is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_pc <= '0;
            bus.out_imm <= '0;
            bus.out_op1 <= '0;
            bus.out_op2 <= '0;
            bus.out_aluop <= ALU_NOP;
            bus.out_alusel <= RES_NOP;
            bus.out_rd <= '0;
            bus.out_wreg <= 1'b0;
            bus.out_illegal <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (adv) begin
            bus.out_valid <= bus.in_valid & in_ready;
            if (bus.in_valid && in_ready) begin
                bus.out_pc <= bus.in_pc;
                bus.out_imm <= imm;
                bus.out_op1 <= op1;
                bus.out_op2 <= op2;
                bus.out_aluop <= aluop;
                bus.out_alusel <= sel_of(aluop);
                bus.out_rd <= rd;
                bus.out_wreg <= legal && rd != REG_NOP;
                bus.out_illegal <= !legal;
            end
        end
    end
endmodule
